// File: rtl/standoff_round_engine.sv
// standoff_round_engine: N-player standoff round timer, validation, shot resolution and scoring; STANDOFF_DUCK_LIMIT_EN forbids consecutive ducks
module standoff_round_engine #(
  parameter int N_PLAYERS = 2,
  parameter int MAX_BULLETS = 3,
  parameter int MAX_LIVES = 3,
  parameter int STEP_CYCLES = 100_000_000,
  parameter int COUNT_STEPS = 7,
  localparam int BW = $clog2(MAX_BULLETS + 1),
  localparam int LW = $clog2(MAX_LIVES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  input  logic [2*N_PLAYERS-1:0]   choice,
  output logic [BW*N_PLAYERS-1:0]  bullets,
  output logic [LW*N_PLAYERS-1:0]  lives,
  output logic [2*N_PLAYERS-1:0]   vchoice,
  output logic [N_PLAYERS-1:0]     hit,
  output logic [COUNT_STEPS-1:0]   countdown,
  output logic                     round_done,
  output logic                     game_over,
  output logic [N_PLAYERS-1:0]     winner
);
  localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] SLAST = CW'(STEP_CYCLES - 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BULLETS);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LIVES);
  localparam logic [2:0] S_IDLE = 3'd0, S_COUNT = 3'd1, S_RESOLVE = 3'd2, S_UPDATE = 3'd3, S_OVER = 3'd4;
  localparam logic [1:0] C_IDLE = 2'b00, C_SHOOT = 2'b01, C_RELOAD = 2'b10, C_DUCK = 2'b11;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [2*N_PLAYERS-1:0] samp, vc_c;
  logic [N_PLAYERS-1:0] shot, hit_c, alive_n, duck_block;
  logic [BW*N_PLAYERS-1:0] bullets_n;
  logic [LW*N_PLAYERS-1:0] lives_n;
  logic [3:0] alive_cnt;
  logic go;
  assign go = (state == S_IDLE || state == S_OVER) && start;
  assign game_over = state == S_OVER;
  always_comb begin
    vc_c = '0;
    shot = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      vc_c[2*i+:2] = (lives[LW*i+:LW] == '0 ||
                      (samp[2*i+:2] == C_SHOOT && bullets[BW*i+:BW] == '0) ||
                      (samp[2*i+:2] == C_RELOAD && bullets[BW*i+:BW] == BMAX) ||
                      (samp[2*i+:2] == C_DUCK && duck_block[i])) ? C_IDLE : samp[2*i+:2];
      shot[i] = vc_c[2*i+:2] == C_SHOOT;
    end
    hit_c = '0;
    bullets_n = bullets;
    lives_n = lives;
    alive_n = '0;
    alive_cnt = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      // a shooter is never hit by its own shot, only by another shooter
      hit_c[i] = lives[LW*i+:LW] != '0 && vc_c[2*i+:2] != C_DUCK && |(shot & ~(N_PLAYERS'(1) << i));
      bullets_n[BW*i+:BW] = vc_c[2*i+:2] == C_SHOOT ? bullets[BW*i+:BW] - BW'(1) :
                            vc_c[2*i+:2] == C_RELOAD ? bullets[BW*i+:BW] + BW'(1) : bullets[BW*i+:BW];
      lives_n[LW*i+:LW] = hit_c[i] ? lives[LW*i+:LW] - LW'(1) : lives[LW*i+:LW];
      alive_n[i] = lives_n[LW*i+:LW] != '0;
      alive_cnt = alive_cnt + 4'(alive_n[i]);
    end
  end
`ifdef STANDOFF_DUCK_LIMIT_EN
  logic [N_PLAYERS-1:0] duck_hist;
  always_ff @(posedge clk) begin
    if (reset || go)
      duck_hist <= '0;
    else if (state == S_UPDATE)
      for (int i = 0; i < N_PLAYERS; i++) duck_hist[i] <= vc_c[2*i+:2] == C_DUCK;
  end
  assign duck_block = duck_hist;
`else
  assign duck_block = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      samp <= '0;
      bullets <= '0;
      lives <= {N_PLAYERS{LMAX}};
      vchoice <= '0;
      hit <= '0;
      countdown <= '1;
      round_done <= 1'b0;
      winner <= '0;
    end else begin
      round_done <= 1'b0;
      case (state)
        S_IDLE, S_OVER: if (start) begin
          state <= S_COUNT;
          cnt <= '0;
          countdown <= '1;
          bullets <= '0;
          lives <= {N_PLAYERS{LMAX}};
          winner <= '0;
        end
        S_COUNT: if (!pause) begin
          cnt <= cnt == SLAST ? '0 : cnt + CW'(1);
          if (cnt == SLAST) begin
            countdown <= countdown >> 1;
            if (countdown == COUNT_STEPS'(1)) begin
              state <= S_RESOLVE;
              samp <= choice;
            end
          end
        end
        S_RESOLVE: state <= S_UPDATE;
        S_UPDATE: begin
          bullets <= bullets_n;
          lives <= lives_n;
          vchoice <= vc_c;
          hit <= hit_c;
          round_done <= 1'b1;
          countdown <= '1;
          cnt <= '0;
          state <= alive_cnt <= 4'd1 ? S_OVER : S_COUNT;
          winner <= alive_cnt == 4'd1 ? alive_n : '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_standoff_round_engine.sv
// tb_standoff_round_engine: randomized and directed rounds checked against a behavioural game model
module tb_standoff_round_engine;
  localparam int N = 2, MB = 3, ML = 3, SC = 4, CS = 3;
`ifdef STANDOFF_DUCK_LIMIT_EN
  localparam bit DL = 1'b1;
`else
  localparam bit DL = 1'b0;
`endif
  localparam logic [1:0] ID = 2'b00, SH = 2'b01, RL = 2'b10, DK = 2'b11;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0;
  logic [2*N-1:0] choice = '0;
  logic [2*N-1:0] bullets, lives, vchoice;
  logic [N-1:0] hit, winner;
  logic [CS-1:0] countdown;
  logic round_done, game_over;
  int checks = 0, failures = 0;
  int mb[N], ml[N];
  bit pd[N];
  logic [2*N-1:0] ev;
  logic [N-1:0] eh, ewin;
  logic eover;

  always #5 clk = ~clk;

  standoff_round_engine #(.N_PLAYERS(N), .MAX_BULLETS(MB), .MAX_LIVES(ML), .STEP_CYCLES(SC), .COUNT_STEPS(CS)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .choice(choice),
    .bullets(bullets), .lives(lives), .vchoice(vchoice), .hit(hit), .countdown(countdown),
    .round_done(round_done), .game_over(game_over), .winner(winner));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*N-1:0] pack(input int a[N]);
    logic [2*N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[2*i+:2] = 2'(a[i]);
    return p;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < N; i++) begin
      mb[i] = 0;
      ml[i] = ML;
      pd[i] = 1'b0;
    end
    eover = 1'b0;
  endtask

  // one round of game rules: validate, count shots from others, then score
  task automatic model_round(input logic [1:0] c0, input logic [1:0] c1);
    int c[N], v[N];
    int others, alive;
    c[0] = c0;
    c[1] = c1;
    for (int i = 0; i < N; i++) begin
      v[i] = c[i];
      if (ml[i] == 0 || (c[i] == 1 && mb[i] == 0) || (c[i] == 2 && mb[i] == MB) || (DL && c[i] == 3 && pd[i]))
        v[i] = 0;
    end
    eh = '0;
    for (int i = 0; i < N; i++) begin
      others = 0;
      for (int j = 0; j < N; j++) if (j != i && v[j] == 1) others++;
      eh[i] = ml[i] > 0 && v[i] != 3 && others > 0;
    end
    alive = 0;
    ewin = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i] == 1) mb[i]--;
      if (v[i] == 2) mb[i]++;
      if (eh[i]) ml[i]--;
      pd[i] = v[i] == 3;
      ev[2*i+:2] = 2'(v[i]);
      if (ml[i] > 0) begin
        alive++;
        ewin[i] = 1'b1;
      end
    end
    eover = alive <= 1;
    if (alive != 1) ewin = '0;
  endtask

  task automatic do_start;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_reset();
    chk("start_countdown", 32'(countdown), 32'(3'b111));
    chk("start_bullets", 32'(bullets), 32'(pack(mb)));
    chk("start_lives", 32'(lives), 32'(pack(ml)));
    chk("start_game_over", 32'(game_over), 0);
    chk("start_winner", 32'(winner), 0);
  endtask

  task automatic run_round(input logic [1:0] c0, input logic [1:0] c1, input int pause_at);
    int n, samp_n;
    logic [CS-1:0] held;
    n = 0;
    held = '0;
    samp_n = pause_at >= 0 ? 22 : 12;
    choice = {c1, c0};
    model_round(c0, c1);
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == samp_n) choice = 4'($urandom);
      if (pause_at >= 0 && n == pause_at) begin
        pause = 1'b1;
        held = countdown;
        chk("pause_countdown", 32'(countdown), 32'(3'b011));
      end
      if (pause_at >= 0 && n == pause_at + 10) begin
        pause = 1'b0;
        chk("pause_frozen", 32'(countdown), 32'(held));
      end
      if (pause_at < 0 && n == 4) chk("countdown_step1", 32'(countdown), 32'(3'b011));
      if (pause_at < 0 && n == 8) chk("countdown_step2", 32'(countdown), 32'(3'b001));
    end while (!round_done && n < 60);
    chk("round_latency", n, pause_at >= 0 ? 24 : 14);
    chk("vchoice", 32'(vchoice), 32'(ev));
    chk("hit", 32'(hit), 32'(eh));
    chk("bullets", 32'(bullets), 32'(pack(mb)));
    chk("lives", 32'(lives), 32'(pack(ml)));
    chk("game_over", 32'(game_over), 32'(eover));
    chk("winner", 32'(winner), 32'(ewin));
  endtask

  initial begin
    int rd;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_bullets", 32'(bullets), 0);
    chk("rst_lives", 32'(lives), 32'(4'hF));
    chk("rst_vchoice", 32'(vchoice), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_countdown", 32'(countdown), 32'(3'b111));
    chk("rst_round_done", 32'(round_done), 0);
    chk("rst_game_over", 32'(game_over), 0);
    chk("rst_winner", 32'(winner), 0);
    rd = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (round_done) rd++;
    end
    chk("idle_no_round", rd, 0);
    do_start();
    run_round(SH, ID, -1);
    chk("empty_gun_vchoice", 32'(vchoice), 0);
    repeat (4) run_round(RL, ID, -1);
    chk("reload_sat_vchoice", 32'(vchoice[1:0]), 32'(ID));
    run_round(SH, DK, -1);
    run_round(ID, ID, -1);
    run_round(SH, DK, -1);
    run_round(ID, ID, -1);
    run_round(SH, DK, -1);
    chk("duck_hit", 32'(hit), 0);
    run_round(RL, ID, -1);
    run_round(SH, ID, -1);
    chk("shot_p1_hit", 32'(hit), 32'(2'b10));
    run_round(ID, RL, -1);
    run_round(ID, SH, -1);
    run_round(RL, RL, -1);
    run_round(SH, SH, -1);
    chk("mutual_hit", 32'(hit), 32'(2'b11));
    run_round(RL, RL, -1);
    run_round(SH, SH, -1);
    chk("draw_game_over", 32'(game_over), 1);
    chk("draw_winner", 32'(winner), 0);
    @(posedge clk);
    #1;
    chk("pulse_width", 32'(round_done), 0);
    chk("game_over_hold", 32'(game_over), 1);
    do_start();
    run_round(ID, ID, 5);
`ifdef STANDOFF_DUCK_LIMIT_EN
    run_round(RL, DK, -1);
    run_round(SH, DK, -1);
    chk("duck_limit_hit", 32'(hit), 32'(2'b10));
`endif
    for (int r = 0; r < 40; r++) begin
      if (eover) do_start();
      run_round(2'($urandom), 2'($urandom), -1);
    end
    if (eover) do_start();
    choice = 4'($urandom);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("mid_rst_lives", 32'(lives), 32'(4'hF));
    chk("mid_rst_bullets", 32'(bullets), 0);
    chk("mid_rst_countdown", 32'(countdown), 32'(3'b111));
    chk("mid_rst_round_done", 32'(round_done), 0);
    rd = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (round_done) rd++;
    end
    chk("mid_rst_no_round", rd, 0);
    do_start();
    run_round(RL, RL, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
